// File: rtl/exception_ctrl_pkg.sv
// Shared encodings for the exception controller: memory-address selects,
// vector addresses, FSM state codes and exception cause codes.
package exception_ctrl_pkg;

  localparam logic [2:0] SRC_PC     = 3'b000;
  localparam logic [2:0] SRC_ALUOUT = 3'b001;
  localparam logic [2:0] SRC_NOOP   = 3'b010;
  localparam logic [2:0] SRC_OVF    = 3'b011;
  localparam logic [2:0] SRC_DIV0   = 3'b100;

  localparam logic [7:0] VEC_NOOP = 8'd253;
  localparam logic [7:0] VEC_OVF  = 8'd254;
  localparam logic [7:0] VEC_DIV0 = 8'd255;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SAVE_EPC = 3'd1;
  localparam logic [2:0] ST_ISSUE    = 3'd2;
  localparam logic [2:0] ST_WAIT     = 3'd3;
  localparam logic [2:0] ST_LOAD_PC  = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_NOOP = 2'b01,
    CAUSE_OVF  = 2'b10,
    CAUSE_DIV0 = 2'b11
  } cause_e;

  // Highest-priority cause among simultaneous requests: div0 > overflow > noop.
  function automatic cause_e pick_cause(input logic div0, input logic ovf, input logic noop);
    if (div0)      return CAUSE_DIV0;
    else if (ovf)  return CAUSE_OVF;
    else if (noop) return CAUSE_NOOP;
    else           return CAUSE_NONE;
  endfunction

  function automatic logic [2:0] cause_to_src(input cause_e c);
    case (c)
      CAUSE_NOOP: return SRC_NOOP;
      CAUSE_OVF:  return SRC_OVF;
      CAUSE_DIV0: return SRC_DIV0;
      default:    return SRC_PC;
    endcase
  endfunction

endpackage

// File: rtl/exception_ctrl_wait_counter.sv
// 3-bit down-counter timing the memory wait; reports when it has reached zero.
module exc_wait_counter
  import exception_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && cnt_q != 3'd0)
      cnt_d = cnt_q - 3'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= 3'd0;
    else          cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == 3'd0);

endmodule

// File: rtl/exception_ctrl.sv
// Exception sequencer: saves EPC, fetches the handler byte from a fixed vector
// and loads the PC. Optional cause/count outputs with macro EXC_CAUSE_REG_EN.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] ctrl_src_sel,
  input  logic       exc_noop,
  input  logic       exc_overflow,
  input  logic       exc_div0,
  output logic [2:0] src_add_mem,
  output logic       epc_write,
  output logic       mem_read,
  output logic       pc_write_exc,
  output logic       ctrl_hold,
  output logic       exc_busy
`ifdef EXC_CAUSE_REG_EN
  , output logic [1:0] exc_cause
  , output logic [7:0] exc_count
`endif
);

  // Counter is loaded with one less than the wait so WAIT lasts exactly MEM_WAIT cycles.
  localparam logic [2:0] WAIT_LOAD = (MEM_WAIT == 0) ? 3'd0 : 3'(MEM_WAIT - 1);

  logic [2:0] state_q, state_d;
  cause_e     cause_q, cause_d;
  logic       epc_q, mr_q, pcw_q;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic [2:0] src_sel;
  logic       exc_any;

  assign exc_any = exc_div0 | exc_overflow | exc_noop;

  exc_wait_counter u_wait (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exc_any) begin
          state_d = ST_SAVE_EPC;
          cause_d = pick_cause(exc_div0, exc_overflow, exc_noop);
        end
      end
      ST_SAVE_EPC: state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (MEM_WAIT == 0) begin
          state_d = ST_LOAD_PC;
        end else begin
          state_d  = ST_WAIT;
          cnt_load = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_zero) state_d = ST_LOAD_PC;
        else          cnt_dec = 1'b1;
      end
      ST_LOAD_PC: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each is high during its own state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cause_q <= CAUSE_NONE;
      epc_q   <= 1'b0;
      mr_q    <= 1'b0;
      pcw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= (state_d == ST_SAVE_EPC);
      mr_q    <= (state_d == ST_ISSUE);
      pcw_q   <= (state_d == ST_LOAD_PC);
    end
  end

  always_comb begin
    src_sel = SRC_PC;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_src_sel == SRC_PC || ctrl_src_sel == SRC_ALUOUT)
          src_sel = ctrl_src_sel;
      end
      ST_ISSUE, ST_WAIT, ST_LOAD_PC: src_sel = cause_to_src(cause_q);
      default: src_sel = SRC_PC;
    endcase
  end

  // The IDLE passthrough is gated so reset forces PC select without waiting for a clock.
  assign src_add_mem  = reset_n ? src_sel : SRC_PC;
  assign epc_write    = epc_q;
  assign mem_read     = mr_q;
  assign pc_write_exc = pcw_q;
  assign exc_busy     = (state_q != ST_IDLE);
  assign ctrl_hold    = exc_busy;

`ifdef EXC_CAUSE_REG_EN
  logic [7:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count_q <= 8'd0;
    else if (state_q == ST_IDLE && state_d == ST_SAVE_EPC && count_q != 8'hFF)
      count_q <= count_q + 8'd1;
  end

  assign exc_cause = cause_q;
  assign exc_count = count_q;
`endif

endmodule
